// File: rtl/bist_pkg.sv
// Shared BIST encodings: pattern modes, analyzer states and default MISR constants.
package bist_pkg;

  typedef enum logic [1:0] {
    MODE_NONE    = 2'b00,
    MODE_RING    = 2'b01,
    MODE_JOHNSON = 2'b10,
    MODE_LFSR    = 2'b11
  } bist_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StCompact,
    StCompare,
    StDone
  } ana_state_e;

  localparam logic [15:0] MISR_POLY_DEFAULT = 16'h002D;
  localparam logic [15:0] MISR_SEED_DEFAULT = 16'h0000;

endpackage

// File: rtl/bist_response_analyzer_if.sv
// Pattern-in / result-out bundle of the BIST response analyzer.
interface bist_response_analyzer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [WIDTH-1:0] signature;
  logic [7:0]       sample_count;

  modport master (
    output start, mode, data_in, data_valid,
    input  busy, done, pass, fail, signature, sample_count
  );

  modport slave (
    input  start, mode, data_in, data_valid,
    output busy, done, pass, fail, signature, sample_count
  );
endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register: seeded on load_i, compacts data_i on en_i.
module bist_misr #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(16'h002D),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sig_q <= SEED;
    else      sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// Compacts a fixed-length pattern stream into a MISR and checks it against a per-mode golden value.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH          = 16,
  parameter int unsigned      NUM_PATTERNS   = 16,
  parameter logic [WIDTH-1:0] MISR_POLY      = WIDTH'(MISR_POLY_DEFAULT),
  parameter logic [WIDTH-1:0] MISR_SEED      = WIDTH'(MISR_SEED_DEFAULT),
  parameter logic [WIDTH-1:0] GOLDEN_RING    = '0,
  parameter logic [WIDTH-1:0] GOLDEN_JOHNSON = '0,
  parameter logic [WIDTH-1:0] GOLDEN_LFSR    = '0
) (
  input logic                     clk,
  input logic                     rst,
  bist_response_analyzer_if.slave bus
);

  ana_state_e       state_q, state_d;
  bist_mode_e       mode_q, mode_d;
  logic [7:0]       count_q, count_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             misr_load, misr_en;
  logic             accept_start;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] golden;

  assign accept_start = bus.start && (bus.mode != MODE_NONE);

  always_comb begin
    golden = '0;
    unique case (mode_q)
      MODE_RING:    golden = GOLDEN_RING;
      MODE_JOHNSON: golden = GOLDEN_JOHNSON;
      MODE_LFSR:    golden = GOLDEN_LFSR;
      default:      golden = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept_start) begin
          mode_d  = bist_mode_e'(bus.mode);
          state_d = StSeed;
        end
      end
      StSeed: begin
        misr_load = 1'b1;
        count_d   = '0;
        state_d   = StCompact;
      end
      StCompact: begin
        if (bus.data_valid) begin
          misr_en = 1'b1;
          count_d = count_q + 8'd1;
          if (count_d == 8'(NUM_PATTERNS)) state_d = StCompare;
        end
      end
      StCompare: begin
        pass_d  = (sig == golden);
        fail_d  = (sig != golden);
        state_d = StDone;
      end
      StDone: begin
        // Result holds until a real restart; done drops with the state change.
        if (accept_start) begin
          mode_d  = bist_mode_e'(bus.mode);
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = StSeed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      mode_q  <= MODE_NONE;
      count_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  bist_misr #(
    .WIDTH (WIDTH),
    .POLY  (MISR_POLY),
    .SEED  (MISR_SEED)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .load_i (misr_load),
    .en_i   (misr_en),
    .data_i (bus.data_in),
    .sig_o  (sig)
  );

  assign bus.busy         = (state_q == StSeed) || (state_q == StCompact) ||
                            (state_q == StCompare);
  assign bus.done         = (state_q == StDone);
  assign bus.pass         = pass_q;
  assign bus.fail         = fail_q;
  assign bus.signature    = sig;
  assign bus.sample_count = count_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed, table-driven bench for the BIST response analyzer (two-sample runs).
module tb_bist_response_analyzer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bist_response_analyzer_if #(.WIDTH(16)) bus ();

  bist_response_analyzer #(
    .WIDTH          (16),
    .NUM_PATTERNS   (2),
    .MISR_POLY      (16'h002D),
    .MISR_SEED      (16'h0000),
    .GOLDEN_RING    (16'h002D),
    .GOLDEN_JOHNSON (16'h1234),
    .GOLDEN_LFSR    (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] d0;
    logic [15:0] d1;
    int          gap;
    logic        mid_start;
    logic [15:0] exp_sig;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_start(input logic [1:0] m);
    bus.mode  = m;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("done_after_start", 32'(bus.done), 32'd0);
    step();
  endtask

  // Drives two samples with a gap, then checks latency and result of the run.
  task automatic do_body(input logic [15:0] d0, input logic [15:0] d1, input int gap,
                         input logic mid_start, input logic [15:0] exp_sig,
                         input logic exp_pass);
    int n;
    bus.data_valid = 1'b1;
    bus.data_in    = d0;
    step();
    bus.data_valid = 1'b0;
    bus.data_in    = 16'hFFFF;
    chk("count_after_first", 32'(bus.sample_count), 32'd1);
    for (int i = 0; i < gap; i++) begin
      if (mid_start && i == 0) begin
        bus.start = 1'b1;
        bus.mode  = 2'b11;
      end
      step();
      bus.start = 1'b0;
      bus.mode  = 2'b00;
      chk("gap_count_hold", 32'(bus.sample_count), 32'd1);
      chk("gap_sig_hold", 32'(bus.signature), 32'(d0));
    end
    bus.data_valid = 1'b1;
    bus.data_in    = d1;
    step();
    bus.data_valid = 1'b0;
    chk("compare_busy", 32'(bus.busy), 32'd1);
    chk("compare_not_done", 32'(bus.done), 32'd0);
    step();
    n = 0;
    while (!bus.done && n < 8) begin
      step();
      n++;
    end
    chk("done_latency", 32'(n), 32'd0);
    chk("done", 32'(bus.done), 32'd1);
    chk("busy_in_done", 32'(bus.busy), 32'd0);
    chk("signature", 32'(bus.signature), 32'(exp_sig));
    chk("sample_count", 32'(bus.sample_count), 32'd2);
    chk("pass", 32'(bus.pass), 32'(exp_pass));
    chk("fail", 32'(bus.fail), 32'(!exp_pass));
  endtask

  initial begin
    vecs[0] = '{2'b01, 16'h8000, 16'h0000, 0, 1'b0, 16'h002D, 1'b1};
    vecs[1] = '{2'b01, 16'h8000, 16'h0001, 0, 1'b0, 16'h002C, 1'b0};
    vecs[2] = '{2'b01, 16'h8000, 16'h0000, 3, 1'b1, 16'h002D, 1'b1};
    vecs[3] = '{2'b10, 16'h091A, 16'h0000, 1, 1'b0, 16'h1234, 1'b1};
    vecs[4] = '{2'b11, 16'h0000, 16'h0000, 0, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{2'b11, 16'hFFFF, 16'hFFFF, 2, 1'b0, 16'h002C, 1'b0};

    bus.start      = 1'b0;
    bus.mode       = 2'b00;
    bus.data_in    = 16'h0000;
    bus.data_valid = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_fail", 32'(bus.fail), 32'd0);
    chk("rst_sig", 32'(bus.signature), 32'h0);
    chk("rst_count", 32'(bus.sample_count), 32'd0);
    rst = 1'b1;
    step();

    // start with mode 00 in IDLE must be ignored
    bus.start = 1'b1;
    bus.mode  = 2'b00;
    step();
    bus.start = 1'b0;
    chk("none_start_busy", 32'(bus.busy), 32'd0);
    step();
    chk("none_start_busy2", 32'(bus.busy), 32'd0);
    chk("none_start_done", 32'(bus.done), 32'd0);

    foreach (vecs[k]) begin
      do_start(vecs[k].mode);
      do_body(vecs[k].d0, vecs[k].d1, vecs[k].gap, vecs[k].mid_start,
              vecs[k].exp_sig, vecs[k].exp_pass);
    end

    // In DONE after a fail: mode 00 start ignored, then a real restart clears the result
    bus.start = 1'b1;
    bus.mode  = 2'b00;
    step();
    bus.start = 1'b0;
    chk("done_none_start_done", 32'(bus.done), 32'd1);
    chk("done_none_start_fail", 32'(bus.fail), 32'd1);
    bus.start = 1'b1;
    bus.mode  = 2'b01;
    step();
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    chk("restart_done", 32'(bus.done), 32'd0);
    chk("restart_fail", 32'(bus.fail), 32'd0);
    chk("restart_pass", 32'(bus.pass), 32'd0);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    step();
    do_body(16'h8000, 16'h0000, 0, 1'b0, 16'h002D, 1'b1);

    // Asynchronous reset in the middle of COMPACT
    do_start(2'b01);
    bus.data_valid = 1'b1;
    bus.data_in    = 16'h8000;
    step();
    bus.data_valid = 1'b0;
    chk("pre_abort_sig", 32'(bus.signature), 32'h8000);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_sig", 32'(bus.signature), 32'h0);
    chk("abort_count", 32'(bus.sample_count), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_pass", 32'(bus.pass), 32'd0);
    #2 rst = 1'b1;
    step();
    chk("post_abort_idle", 32'(bus.busy), 32'd0);
    do_start(2'b01);
    do_body(16'h8000, 16'h0000, 0, 1'b0, 16'h002D, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
